// File: rtl/input_control.sv
// Deserializes a 1-bit operand stream into N x N matrices A and B, clears the
// systolic core, drives skewed row/column wavefronts, then pulses init.
module input_control_lane #(
   parameter int D_W = 8,
   parameter int N   = 2,
   parameter int IDX = 0,
   parameter int TW  = 2
) (
   input  logic                  feed_i,
   input  logic [TW-1:0]         t_i,
   input  logic [N-1:0][D_W-1:0] vec_i,
   output logic [D_W-1:0]        lane_o
);
   // Lane IDX carries element k of its vector at feed step IDX+k; zero otherwise.
   always_comb begin
      lane_o = '0;
      for (int k = 0; k < N; k++)
         if (feed_i && int'(t_i) == IDX + k) lane_o = vec_i[k];
   end
endmodule

module input_control #(
   parameter int D_W = 8,
   parameter int N   = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           data_in,
   input  logic           data_valid,
   output logic           rx_ready,
   output logic [N*D_W-1:0] core_in_a,
   output logic [N*D_W-1:0] core_in_b,
   output logic           core_valid,
   output logic           core_clr,
   output logic           init,
   output logic           busy
);
   localparam int NN = N * N;
   localparam int BW = $clog2(D_W);
   localparam int EW = $clog2(2 * NN);
   localparam int TW = $clog2(2 * N - 1);

   typedef enum logic [2:0] {IDLE, LOAD, CLR, FEED, DONE} state_t;

   state_t                  state_q, state_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [EW-1:0]           elem_q, elem_d;
   logic [TW-1:0]           t_q, t_d;
   logic [NN-1:0][D_W-1:0]  a_q, b_q;
   logic                    accept;

   assign rx_ready   = (state_q == IDLE) || (state_q == LOAD);
   assign busy       = (state_q != IDLE);
   assign core_clr   = (state_q == CLR);
   assign core_valid = (state_q == FEED);
   assign init       = (state_q == DONE);
   assign accept     = data_valid && rx_ready;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      elem_d  = elem_q;
      t_d     = t_q;
      unique case (state_q)
         IDLE, LOAD: if (data_valid) begin
            state_d = LOAD;
            if (bit_q == BW'(D_W - 1)) begin
               bit_d = '0;
               if (elem_q == EW'(2 * NN - 1)) begin
                  elem_d  = '0;
                  state_d = CLR;
               end else begin
                  elem_d = elem_q + EW'(1);
               end
            end else begin
               bit_d = bit_q + BW'(1);
            end
         end
         CLR: begin
            t_d     = '0;
            state_d = FEED;
         end
         FEED: if (t_q == TW'(2 * N - 2)) state_d = DONE;
               else t_d = t_q + TW'(1);
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bit_q   <= '0;
         elem_q  <= '0;
         t_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         elem_q  <= elem_d;
         t_q     <= t_d;
         // Element index decoded per entry so N*N need not be a power of two.
         for (int e = 0; e < NN; e++) begin
            if (accept && elem_q == EW'(e))      a_q[e][bit_q] <= data_in;
            if (accept && elem_q == EW'(e + NN)) b_q[e][bit_q] <= data_in;
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [N-1:0][D_W-1:0] col;
      for (genvar k = 0; k < N; k++) begin : g_col
         assign col[k] = b_q[k*N + i];
      end
      input_control_lane #(.D_W(D_W), .N(N), .IDX(i), .TW(TW)) u_a (
         .feed_i (core_valid),
         .t_i    (t_q),
         .vec_i  (a_q[i*N +: N]),
         .lane_o (core_in_a[i*D_W +: D_W])
      );
      input_control_lane #(.D_W(D_W), .N(N), .IDX(i), .TW(TW)) u_b (
         .feed_i (core_valid),
         .t_i    (t_q),
         .vec_i  (col),
         .lane_o (core_in_b[i*D_W +: D_W])
      );
   end
endmodule

// File: tb/tb_input_control.sv
// Randomized scoreboard bench for input_control: stimulus pushes the expected
// CLR/FEED/DONE sequence, a negedge monitor pops and compares.
module tb_input_control;
   localparam int D_W = 8;
   localparam int N   = 2;
   localparam int NN  = N * N;
   localparam int LW  = N * D_W;

   typedef logic [NN-1:0][D_W-1:0] mat_t;
   typedef struct {
      logic [2:0]    kind;   // {clr, valid, init}
      int            at;
      logic [LW-1:0] a;
      logic [LW-1:0] b;
   } exp_t;

   exp_t sbq[$];

   logic clk = 0, rst = 0, data_in = 0, data_valid = 0;
   logic rx_ready, core_valid, core_clr, init, busy;
   logic [LW-1:0] core_in_a, core_in_b;

   int total = 0, bad = 0, cyc = 0, clr_cnt = 0, init_cnt = 0, loads = 0;
   bit prev_init = 0;

   input_control #(.D_W(D_W), .N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .rx_ready   (rx_ready),
      .core_in_a  (core_in_a),
      .core_in_b  (core_in_b),
      .core_valid (core_valid),
      .core_clr   (core_clr),
      .init       (init),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // Left edge at step t: row i shows A[i][t-i] when that column exists.
   function automatic logic [LW-1:0] lanes_a(input mat_t m, input int t);
      logic [LW-1:0] r = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) r[i*D_W +: D_W] = m[i*N + (t - i)];
      return r;
   endfunction

   function automatic logic [LW-1:0] lanes_b(input mat_t m, input int t);
      logic [LW-1:0] r = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < N) r[j*D_W +: D_W] = m[(t - j)*N + j];
      return r;
   endfunction

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_ctl"}, {59'd0, busy, rx_ready, core_valid, core_clr, init}, 64'b01000);
      chk({nm, "_lanes"}, {32'd0, core_in_a, core_in_b}, 64'd0);
   endtask

   // Streams both matrices LSB first; abort_at>0 resets asynchronously after that many bits.
   task automatic load(input mat_t ma, input mat_t mb, input int maxgap,
                       input bit junk, input int abort_at);
      int n = 0;
      exp_t x;
      for (int e = 0; e < 2*NN; e++) begin
         for (int k = 0; k < D_W; k++) begin
            repeat ($urandom_range(0, maxgap)) begin
               data_valid = 0; data_in = 1'($urandom);
               @(posedge clk); #1;
            end
            data_valid = 1;
            data_in = (e < NN) ? ma[e][k] : mb[e-NN][k];
            @(posedge clk); #1;
            n++;
            if (n == abort_at) begin
               data_valid = 0;
               #2 rst = 0;
               #1 check_reset_outputs("mid_load_reset");
               chk("mid_load_sb_empty", sbq.size(), 0);
               @(posedge clk); #2 rst = 1;
               @(posedge clk); #1;
               return;
            end
         end
      end
      data_valid = 0;
      x.kind = 3'b100; x.at = cyc; x.a = '0; x.b = '0;
      sbq.push_back(x);
      for (int t = 0; t < 2*N-1; t++) begin
         x.kind = 3'b010; x.at = cyc + 1 + t; x.a = lanes_a(ma, t); x.b = lanes_b(mb, t);
         sbq.push_back(x);
      end
      x.kind = 3'b001; x.at = cyc + 2*N; x.a = '0; x.b = '0;
      sbq.push_back(x);
      loads++;
      repeat (2*N + 1) begin
         data_valid = junk; data_in = 1'($urandom);
         @(posedge clk); #1;
      end
      data_valid = 0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (prev_init) chk("busy_after_init", busy, 0);
         prev_init = init;
         if (core_clr || core_valid || init) begin
            if (core_clr) clr_cnt++;
            if (init) init_cnt++;
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_pulse got={%b%b%b} want=none (cycle %0d)",
                        core_clr, core_valid, init, cyc);
            end else begin
               e = sbq.pop_front();
               chk("pulse_kind", {61'd0, core_clr, core_valid, init}, {61'd0, e.kind});
               chk("pulse_cycle", cyc, e.at);
               chk("core_in_a", core_in_a, e.a);
               chk("core_in_b", core_in_b, e.b);
               chk("rx_ready_low", rx_ready, 0);
               chk("busy_high", busy, 1);
            end
         end else begin
            chk("lanes_quiet", {32'd0, core_in_a, core_in_b}, 64'd0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mat_t ma1, mb1, maf, mb01, mr, mbr;
      for (int e = 0; e < NN; e++) begin
         ma1[e] = D_W'(e + 1);
         mb1[e] = D_W'(e + 5);
         maf[e] = '1;
         mb01[e] = D_W'(1);
      end
      #3 check_reset_outputs("reset");
      @(posedge clk); #2 rst = 1;
      @(posedge clk); #1;
      check_reset_outputs("idle_after_reset");

      load(ma1, mb1, 0, 0, -1);   // basic
      load(ma1, mb1, 5, 0, -1);   // stalls
      load(ma1, mb1, 2, 1, -1);   // junk during CLR/FEED/DONE
      repeat (4) @(posedge clk);
      #1 chk("no_extra_load", busy, 0);
      load(ma1, mb1, 1, 0, 30);   // reset mid-load
      load(ma1, mb1, 0, 0, -1);
      load(maf, mb01, 0, 0, -1);  // back-to-back
      for (int r = 0; r < 4; r++) begin
         for (int e = 0; e < NN; e++) begin
            mr[e]  = D_W'($urandom);
            mbr[e] = D_W'($urandom);
         end
         load(mr, mbr, $urandom_range(0, 3), 1'($urandom), -1);
      end
      repeat (10) @(posedge clk);
      #1;
      chk("sb_drained", sbq.size(), 0);
      chk("clr_count", clr_cnt, loads);
      chk("init_count", init_cnt, loads);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
